mem_write_ctrl: RTL and testbench
=================================

# mem_write_ctrl

Write controller sitting directly downstream of the load-button debouncer. It converts each debounced load pulse into exactly one memory write of the switch value at an auto-incrementing address. It holds the write request until the memory acknowledges or a timeout expires, and reports busy, full and error status to the LEDs/MicroBlaze side.

## Interface
Parameters:
- DATA_W, default 8: width of switch data and memory word.
- ADDR_W, default 4: memory address width; depth = 2^ADDR_W words.
- ACK_TIMEOUT, default 15: maximum cycles mem_we is held waiting for mem_ack (1..255).

Ports:
- clk  in  1  100 MHz system clock; one clock domain, all logic on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- load_pulse  in  1  debounced load pulse; may stay high for many clk cycles (typically 10).
- sw_data  in  DATA_W  switch value to store.
- clr  in  1  synchronous clear of address, count and error.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data, stable while mem_we=1.
- mem_we  out  1  write request, held until ack or timeout.
- mem_ack  in  1  memory accepted the write (sampled only while mem_we=1).
- busy  out  1  write in progress.
- full  out  1  all 2^ADDR_W locations written.
- err  out  1  sticky: a write timed out.
- wr_count  out  ADDR_W+1  number of successful writes.

## Operation
- Reset values: mem_addr=0, mem_wdata=0, mem_we=0, busy=0, full=0, err=0, wr_count=0, state IDLE.
- load_pulse is rising-edge detected (registered previous value, reset 0); only the 0->1 edge triggers a write, so a pulse of any length yields one write.
- States:
  - IDLE: on an edge with full=0 and clr=0, latch sw_data into mem_wdata, reset the timeout counter, and go to WRITE. An edge with full=1 is discarded.
  - WRITE: mem_we=1, busy=1. On mem_ack=1, go to IDLE; mem_addr and wr_count increment. If the timeout counter reaches ACK_TIMEOUT without ack, set err, go to IDLE, and leave the address and count unchanged (the write is lost).
- Edges arriving in WRITE are dropped, not queued.
- full = (wr_count == 2^ADDR_W). mem_addr does not wrap: after the last write it stays at its all-ones value. Further writes are refused until clr.
- clr has priority in every state. Next cycle: state IDLE, mem_we=0, mem_addr=0, wr_count=0, err=0, full=0. A simultaneous load edge is discarded. clr during WRITE aborts the write, and a late ack is ignored.
- mem_ack while mem_we=0 is ignored.
- Reset mid-write drops mem_we asynchronously.

## Timing
- Edge seen at cycle N (load_pulse=1 at N, 0 at N-1). mem_we=1 at N+1, with mem_wdata = sw_data sampled at N and mem_addr = the pre-increment address.
- mem_ack=1 in cycle M (M ≥ N+1; zero-wait ack in the first WRITE cycle is legal). At M+1: mem_we=0, busy=0, mem_addr+1, wr_count+1, full updated.
- Without ack, mem_we is high for exactly ACK_TIMEOUT cycles (N+1 .. N+ACK_TIMEOUT). err=1 and mem_we=0 at N+ACK_TIMEOUT+1.
- Earliest next accepted edge: the cycle busy returns to 0.

## Structure
- Shared package mem_ctrl_pkg:
  - state enum IDLE/WRITE;
  - default DATA_W/ADDR_W constants shared with the memory and debouncer top level.
- Sub-module rise_detect (clk, rst, in, out pulse): one-flop edge detector, reusable for other debounced buttons.
- Remainder: a single FSM plus address, count and timeout counters.

## Test plan
- Single write: sw_data=0xA5, load_pulse high 10 cycles, ack 2 cycles after mem_we → exactly one write, addr 0, data 0xA5; then mem_addr=1, wr_count=1.
- Fill: 16 pulses with zero-wait ack (ADDR_W=4) → full=1 after the 16th write, mem_addr=15. A 17th pulse produces no mem_we.
- Timeout: never ack → mem_we high 15 cycles, then err=1, mem_addr and wr_count unchanged. The next pulse with ack succeeds at the same address.
- Busy drop: second load edge during WRITE → ignored; only one write, wr_count=1.
- clr mid-write: clr during WRITE, then ack next cycle → mem_we=0, addr=0, count=0, err=0, ack ignored.
- Async reset asserted during WRITE → all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and default sizes for the switch-to-memory
//               write path.
//               - state_t : write controller states (IDLE / WRITE).
//               - c_DEFAULT_DATA_W / c_DEFAULT_ADDR_W : word and address
//                 widths shared with the memory and debouncer top level.
//               - c_TMO_W : width of the ack timeout counter (1..255).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int c_DEFAULT_DATA_W = 8;
    localparam int c_DEFAULT_ADDR_W = 4;
    localparam int c_TMO_W          = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : One-flop rising-edge detector for an already synchronised,
//               debounced level. pulse is high for the single cycle in which
//               sig is 1 and was 0 in the previous cycle.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset (previous value clears to 0)
//   sig   in  debounced level input
//   pulse out single-cycle rising-edge indication (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= sig;
        end
    end

    // Combinational so the edge is visible in the same cycle the level rises.
    assign pulse = sig & ~r_prev;

endmodule : rise_detect
`default_nettype wire

// File: rtl/mem_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_ctrl
// Description : Turns each debounced load pulse into exactly one memory write
//               of the switch value at an auto-incrementing address. The
//               request is held until the memory acks or a timeout expires.
//   clk        in  system clock
//   rst        in  asynchronous active-high reset
//   load_pulse in  debounced load level (edge triggered internally)
//   sw_data    in  switch value to store
//   clr        in  synchronous clear of address, count and error
//   mem_addr   out write address
//   mem_wdata  out write data, stable while mem_we=1
//   mem_we     out write request
//   mem_ack    in  memory accepted the write
//   busy       out write in progress
//   full       out all 2^ADDR_W locations written
//   err        out sticky write-timeout flag
//   wr_count   out number of successful writes
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = c_DEFAULT_DATA_W,
    parameter int ADDR_W      = c_DEFAULT_ADDR_W,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_pulse,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   wr_count
);

    // wr_count value at which every location has been written.
    localparam logic [ADDR_W:0]    c_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    // Counter starts at 0 in the first WRITE cycle, so the last allowed
    // waiting cycle is ACK_TIMEOUT-1.
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);

    logic               w_load_edge;
    state_t             r_state;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [ADDR_W:0]    w_count_inc;

    assign w_count_inc = wr_count + 1'b1;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst   (rst),
        .sig   (load_pulse),
        .pulse (w_load_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tmo_cnt <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            wr_count  <= '0;
        end else if (clr) begin
            // Clear wins over everything, including a pending ack or a
            // simultaneous load edge. mem_wdata keeps its last value.
            r_state   <= IDLE;
            r_tmo_cnt <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            wr_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load_edge && !full) begin
                        mem_wdata <= sw_data;
                        r_tmo_cnt <= '0;
                        mem_we    <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= WRITE;
                    end
                end

                WRITE: begin
                    // Load edges seen here are intentionally dropped.
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        busy     <= 1'b0;
                        r_state  <= IDLE;
                        wr_count <= w_count_inc;
                        full     <= (w_count_inc == c_DEPTH);
                        // No wrap: the last location's address is retained.
                        if (mem_addr != {ADDR_W{1'b1}}) begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        // Write is lost; address and count stay put.
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_write_ctrl
`default_nettype wire

// File: tb/tb_mem_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_write_ctrl
// Description : Directed self-checking bench for mem_write_ctrl with the
//               default sizes (DATA_W=8, ADDR_W=4, ACK_TIMEOUT=15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_pulse;
    logic [7:0] sw_data;
    logic       clr;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_ack;
    logic       busy;
    logic       full;
    logic       err;
    logic [4:0] wr_count;

    int checks = 0;
    int errors = 0;

    // Write-request activity monitor: number of mem_we rising edges and
    // number of clock edges at which mem_we was high.
    logic prev_we = 1'b0;
    int   we_rises = 0;
    int   we_high  = 0;

    mem_write_ctrl #(
        .DATA_W      (8),
        .ADDR_W      (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_pulse (load_pulse),
        .sw_data    (sw_data),
        .clr        (clr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .full       (full),
        .err        (err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prev_we <= mem_we;
        if (mem_we) we_high <= we_high + 1;
        if (mem_we && !prev_we) we_rises <= we_rises + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise load with data d; held for `hold` cycles; ack driven for one
    // cycle at WRITE cycle index ack_dly (0 = zero-wait), -1 = never.
    task automatic write_txn(input logic [7:0] d, input int hold, input int ack_dly, input int cycles);
        sw_data    = d;
        load_pulse = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (i + 1 >= hold) load_pulse = 1'b0;
            mem_ack = (ack_dly >= 0) && (i == ack_dly);
        end
        mem_ack    = 1'b0;
        load_pulse = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    int rises0;
    int high0;

    initial begin
        rst        = 1'b1;
        load_pulse = 1'b0;
        sw_data    = 8'h00;
        clr        = 1'b0;
        mem_ack    = 1'b0;
        tick();
        tick();

        // ---------------- reset values ----------------
        check("rst_addr",  32'(mem_addr),  32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_we",    32'(mem_we),    32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_full",  32'(full),      32'h0);
        check("rst_err",   32'(err),       32'h0);
        check("rst_count", 32'(wr_count),  32'h0);
        rst = 1'b0;
        tick();

        // ---------------- single write, load held 10 cycles, ack after 2 ----
        rises0     = we_rises;
        sw_data    = 8'hA5;
        load_pulse = 1'b1;
        tick();
        check("s1_we",    32'(mem_we),    32'h1);
        check("s1_busy",  32'(busy),      32'h1);
        check("s1_addr",  32'(mem_addr),  32'h0);
        check("s1_wdata", 32'(mem_wdata), 32'hA5);
        sw_data = 8'h3C;                         // must not disturb held data
        tick();
        tick();
        check("s1_hold_wdata", 32'(mem_wdata), 32'hA5);
        check("s1_hold_we",    32'(mem_we),    32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("s1_done_we",    32'(mem_we),   32'h0);
        check("s1_done_busy",  32'(busy),     32'h0);
        check("s1_done_addr",  32'(mem_addr), 32'h1);
        check("s1_done_count", 32'(wr_count), 32'h1);
        for (int i = 0; i < 8; i++) tick();      // load still high: no re-trigger
        load_pulse = 1'b0;
        tick();
        tick();
        check("s1_one_write", 32'(we_rises - rises0), 32'h1);
        check("s1_count_hold", 32'(wr_count), 32'h1);

        // ---------------- second edge during WRITE is dropped ----------------
        rises0     = we_rises;
        sw_data    = 8'h11;
        load_pulse = 1'b1;
        tick();                                  // WRITE cycle 0
        load_pulse = 1'b0;
        tick();
        sw_data    = 8'h22;
        load_pulse = 1'b1;                       // edge while busy
        tick();
        load_pulse = 1'b0;
        mem_ack    = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        check("bd_wdata", 32'(mem_wdata), 32'h11);
        check("bd_rises", 32'(we_rises - rises0), 32'h1);
        check("bd_count", 32'(wr_count), 32'h2);
        check("bd_addr",  32'(mem_addr), 32'h2);
        check("bd_we",    32'(mem_we),   32'h0);

        // ---------------- timeout ----------------
        high0 = we_high;
        write_txn(8'h5A, 1, -1, 17);
        check("to_high_cycles", 32'(we_high - high0), 32'd15);
        check("to_err",   32'(err),      32'h1);
        check("to_we",    32'(mem_we),   32'h0);
        check("to_addr",  32'(mem_addr), 32'h2);
        check("to_count", 32'(wr_count), 32'h2);
        // retry with zero-wait ack succeeds at the same address
        sw_data    = 8'h77;
        load_pulse = 1'b1;
        tick();
        check("rt_addr", 32'(mem_addr), 32'h2);
        mem_ack    = 1'b1;
        load_pulse = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("rt_addr_inc", 32'(mem_addr), 32'h3);
        check("rt_count",    32'(wr_count), 32'h3);
        check("rt_err_sticky", 32'(err),    32'h1);
        tick();

        // ---------------- clr mid-write, late ack ignored ----------------
        sw_data    = 8'h99;
        load_pulse = 1'b1;
        tick();
        load_pulse = 1'b0;
        check("cm_we_before", 32'(mem_we), 32'h1);
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        mem_ack = 1'b1;
        check("cm_we",    32'(mem_we),   32'h0);
        check("cm_addr",  32'(mem_addr), 32'h0);
        check("cm_count", 32'(wr_count), 32'h0);
        check("cm_err",   32'(err),      32'h0);
        check("cm_busy",  32'(busy),     32'h0);
        tick();
        mem_ack = 1'b0;
        check("cm_ack_ign_addr",  32'(mem_addr), 32'h0);
        check("cm_ack_ign_count", 32'(wr_count), 32'h0);
        tick();

        // ---------------- fill all 16 locations ----------------
        for (int k = 0; k < 16; k++) begin
            write_txn(8'(k + 8'h40), 1, 0, 2);
            if (k == 14) check("fill_not_full_15", 32'(full), 32'h0);
        end
        check("fill_full",  32'(full),     32'h1);
        check("fill_addr",  32'(mem_addr), 32'hF);
        check("fill_count", 32'(wr_count), 32'd16);
        check("fill_wdata", 32'(mem_wdata), 32'h4F);
        rises0 = we_rises;
        write_txn(8'hEE, 1, 0, 4);
        check("full_refuse_rises", 32'(we_rises - rises0), 32'h0);
        check("full_refuse_count", 32'(wr_count), 32'd16);
        check("full_refuse_addr",  32'(mem_addr), 32'hF);

        // ---------------- clr with simultaneous load edge ----------------
        rises0     = we_rises;
        sw_data    = 8'hC3;
        clr        = 1'b1;
        load_pulse = 1'b1;
        tick();
        clr = 1'b0;
        check("cs_full",  32'(full),     32'h0);
        check("cs_count", 32'(wr_count), 32'h0);
        tick();
        tick();
        load_pulse = 1'b0;
        check("cs_no_write", 32'(we_rises - rises0), 32'h0);
        check("cs_we",       32'(mem_we), 32'h0);
        tick();

        // ---------------- async reset mid-write ----------------
        write_txn(8'h12, 1, 0, 2);
        check("ar_pre_addr", 32'(mem_addr), 32'h1);
        sw_data    = 8'h34;
        load_pulse = 1'b1;
        tick();
        load_pulse = 1'b0;
        check("ar_we_before", 32'(mem_we), 32'h1);
        #1 rst = 1'b1;
        #1;                                      // still well before next edge
        check("ar_we",    32'(mem_we),    32'h0);
        check("ar_busy",  32'(busy),      32'h0);
        check("ar_addr",  32'(mem_addr),  32'h0);
        check("ar_wdata", 32'(mem_wdata), 32'h0);
        check("ar_count", 32'(wr_count),  32'h0);
        check("ar_full",  32'(full),      32'h0);
        check("ar_err",   32'(err),       32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_write_ctrl
`default_nettype wire
